// File: rtl/race_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : race_sequencer
// Description : Race controller for two physics engines. Generates the game
//               tick, the shared game state, a one-cycle physics reset, the
//               start countdown, per-car lap counting (checkpoint then finish
//               line), pause handling and winner detection.
// Revision    : 1.0 - initial release
// ============================================================================
module race_sequencer #(
  parameter int         CLK_FREQ  = 100_000_000,
  parameter int         TICK_HZ   = 60,
  parameter int         COUNT_SEC = 3,
  parameter int         LAPS      = 3,
  parameter logic [9:0] FIN_X0    = 10'd0,
  parameter logic [9:0] FIN_X1    = 10'd20,
  parameter logic [9:0] FIN_Y0    = 10'd100,
  parameter logic [9:0] FIN_Y1    = 10'd140,
  parameter logic [9:0] CP_X0     = 10'd280,
  parameter logic [9:0] CP_X1     = 10'd320,
  parameter logic [9:0] CP_Y0     = 10'd100,
  parameter logic [9:0] CP_Y1     = 10'd140
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic [9:0] p1_x,
  input  logic [9:0] p1_y,
  input  logic [9:0] p2_x,
  input  logic [9:0] p2_y,
  output logic       game_tick,
  output logic [2:0] state,
  output logic       phys_rst,
  output logic [1:0] countdown,
  output logic [3:0] p1_lap,
  output logic [3:0] p2_lap,
  output logic [1:0] winner
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int c_TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int c_TW       = (c_TICK_DIV > 1) ? $clog2(c_TICK_DIV) : 1;
  localparam int c_SW       = (TICK_HZ > 1) ? $clog2(TICK_HZ) : 1;

  localparam logic [c_TW-1:0] c_TICK_LAST  = c_TW'(c_TICK_DIV - 1);
  localparam logic [c_TW-1:0] c_TICK_ONE   = c_TW'(1);
  localparam logic [c_SW-1:0] c_SEC_LAST   = c_SW'(TICK_HZ - 1);
  localparam logic [c_SW-1:0] c_SEC_ONE    = c_SW'(1);
  localparam logic [1:0]      c_COUNT_INIT = 2'(COUNT_SEC);
  localparam logic [3:0]      c_LAPS       = 4'(LAPS);

  // Game state encoding shared with the physics engines
  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_COUNT  = 3'd1;
  localparam logic [2:0] c_ST_RACE   = 3'd4;
  localparam logic [2:0] c_ST_PAUSE  = 3'd5;
  localparam logic [2:0] c_ST_FINISH = 3'd6;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [c_TW-1:0] r_tick_cnt;
  logic [2:0]      r_state;
  logic [c_SW-1:0] r_sec;
  logic [1:0]      r_countdown;
  logic            r_phys_rst;
  logic [3:0]      r_lap [2];
  logic [1:0]      r_cp;
  logic [1:0]      r_winner;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic       w_tick;
  logic       w_start_race;
  logic       w_restart;
  logic       w_clear;
  logic       w_race_tick;
  logic       w_sec_wrap;
  logic       w_count_done;
  logic       w_finish;

  logic [9:0] w_car_x [2];
  logic [9:0] w_car_y [2];
  logic [1:0] w_in_cp;
  logic [1:0] w_in_fin;
  logic [1:0] w_lap_step;
  logic [1:0] w_done;
  logic [3:0] w_lap_nx [2];

  // Inclusive unsigned rectangle test; wrapped negative coordinates are
  // simply large values and fall outside both zones.
  function automatic logic in_rect(
    input logic [9:0] x,
    input logic [9:0] y,
    input logic [9:0] x0,
    input logic [9:0] x1,
    input logic [9:0] y0,
    input logic [9:0] y1
  );
    return (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
  endfunction

  assign w_tick       = (r_tick_cnt == c_TICK_LAST);
  assign w_start_race = (r_state == c_ST_IDLE) && start_btn;
  assign w_restart    = (r_state == c_ST_FINISH) && start_btn;
  assign w_clear      = w_start_race || w_restart;
  assign w_race_tick  = (r_state == c_ST_RACE) && w_tick;

  // The last tick of each second rolls the seconds counter; the roll that
  // takes the countdown from 1 to 0 also starts the race.
  assign w_sec_wrap   = (r_state == c_ST_COUNT) && w_tick && (r_sec == c_SEC_LAST);
  assign w_count_done = w_sec_wrap && (r_countdown == 2'd1);

  assign w_car_x[0] = p1_x;
  assign w_car_y[0] = p1_y;
  assign w_car_x[1] = p2_x;
  assign w_car_y[1] = p2_y;

  // Per-car zone detection and next-lap value. A lap only counts when the
  // car reaches the finish zone after having visited the checkpoint, and the
  // count never goes past the target.
  for (genvar gi = 0; gi < 2; gi++) begin : g_car
    assign w_in_cp[gi]    = in_rect(w_car_x[gi], w_car_y[gi], CP_X0, CP_X1, CP_Y0, CP_Y1);
    assign w_in_fin[gi]   = in_rect(w_car_x[gi], w_car_y[gi], FIN_X0, FIN_X1, FIN_Y0, FIN_Y1);
    assign w_lap_step[gi] = w_race_tick && w_in_fin[gi] && r_cp[gi] && (r_lap[gi] != c_LAPS);
    assign w_lap_nx[gi]   = r_lap[gi] + {3'b000, w_lap_step[gi]};
    assign w_done[gi]     = (w_lap_nx[gi] == c_LAPS);
  end

  // Finish is judged on the lap values about to be written, so the state
  // change and the winner land on the same edge as the deciding lap.
  assign w_finish = (r_state == c_ST_RACE) && (|w_done);

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------

  // Free-running tick divider, active in every state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + c_TICK_ONE;
    end
  end

  // Game state machine
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (start_btn) r_state <= c_ST_COUNT;
        end
        c_ST_COUNT: begin
          if (w_count_done) r_state <= c_ST_RACE;
        end
        c_ST_RACE: begin
          if (w_finish) begin
            r_state <= c_ST_FINISH;
          end else if (pause_btn) begin
            r_state <= c_ST_PAUSE;
          end
        end
        c_ST_PAUSE: begin
          if (pause_btn) r_state <= c_ST_RACE;
        end
        c_ST_FINISH: begin
          if (start_btn) r_state <= c_ST_IDLE;
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  // Countdown seconds and the sub-second tick counter behind them
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sec       <= '0;
      r_countdown <= 2'd0;
    end else if (w_start_race) begin
      r_sec       <= '0;
      r_countdown <= c_COUNT_INIT;
    end else if (w_sec_wrap) begin
      r_sec       <= '0;
      r_countdown <= r_countdown - 2'd1;
    end else if ((r_state == c_ST_COUNT) && w_tick) begin
      r_sec <= r_sec + c_SEC_ONE;
    end
  end

  // Physics reset pulses only on the edge that leaves IDLE for COUNTDOWN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phys_rst <= 1'b0;
    end else begin
      r_phys_rst <= w_start_race;
    end
  end

  // Lap counters and checkpoint flags; frozen outside RACE ticks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        r_lap[i] <= 4'd0;
      end
      r_cp <= 2'b00;
    end else if (w_clear) begin
      for (int i = 0; i < 2; i++) begin
        r_lap[i] <= 4'd0;
      end
      r_cp <= 2'b00;
    end else if (w_race_tick) begin
      for (int i = 0; i < 2; i++) begin
        r_lap[i] <= w_lap_nx[i];
        if (w_in_cp[i]) begin
          r_cp[i] <= 1'b1;
        end else if (w_lap_step[i]) begin
          r_cp[i] <= 1'b0;
        end
      end
    end
  end

  // Winner: bit 0 is car 1, bit 1 is car 2, both set on a tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_winner <= 2'd0;
    end else if (w_clear) begin
      r_winner <= 2'd0;
    end else if (w_finish) begin
      r_winner <= {w_done[1], w_done[0]};
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign game_tick = w_tick;
  assign state     = r_state;
  assign phys_rst  = r_phys_rst;
  assign countdown = r_countdown;
  assign p1_lap    = r_lap[0];
  assign p2_lap    = r_lap[1];
  assign winner    = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_race_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_race_sequencer
// Description : Self-checking bench for race_sequencer with a cycle-level
//               reference model, a scripted vector table and random races.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_race_sequencer;

  localparam int CLK_FREQ  = 600;
  localparam int TICK_HZ   = 60;
  localparam int COUNT_SEC = 3;
  localparam int LAPS      = 3;
  localparam int TDIV      = CLK_FREQ / TICK_HZ;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_btn = 1'b0;
  logic       pause_btn = 1'b0;
  logic [9:0] p1_x = 10'd500;
  logic [9:0] p1_y = 10'd500;
  logic [9:0] p2_x = 10'd500;
  logic [9:0] p2_y = 10'd500;
  logic       game_tick;
  logic [2:0] state;
  logic       phys_rst;
  logic [1:0] countdown;
  logic [3:0] p1_lap;
  logic [3:0] p2_lap;
  logic [1:0] winner;

  race_sequencer #(
    .CLK_FREQ (CLK_FREQ),
    .TICK_HZ  (TICK_HZ),
    .COUNT_SEC(COUNT_SEC),
    .LAPS     (LAPS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start_btn(start_btn),
    .pause_btn(pause_btn),
    .p1_x     (p1_x),
    .p1_y     (p1_y),
    .p2_x     (p2_x),
    .p2_y     (p2_y),
    .game_tick(game_tick),
    .state    (state),
    .phys_rst (phys_rst),
    .countdown(countdown),
    .p1_lap   (p1_lap),
    .p2_lap   (p2_lap),
    .winner   (winner)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: cycles since reset release, ticks since countdown entry
  int m_state, m_n, m_cdt, m_win, m_prst;
  int m_lap [2];
  int m_cp  [2];

  typedef struct {
    bit st;
    bit pa;
    int x1, y1, x2, y2;
    int nt;
    int e_state, e_l1, e_l2, e_win;
  } vec_t;

  vec_t tbl [19];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      if (bad >= 100) begin
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  endtask

  function automatic bit in_box(input int x, input int y, input int x0, input int x1,
                                input int y0, input int y1);
    return (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
  endfunction

  task automatic m_reset();
    m_state = 0; m_n = 0; m_cdt = 0; m_win = 0; m_prst = 0;
    for (int i = 0; i < 2; i++) begin
      m_lap[i] = 0;
      m_cp[i]  = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs present at the edge
  task automatic model_edge();
    bit tk;
    int cx [2];
    int cy [2];
    tk = (m_n % TDIV) == (TDIV - 1);
    cx[0] = p1_x; cy[0] = p1_y; cx[1] = p2_x; cy[1] = p2_y;
    m_prst = 0;
    case (m_state)
      0: if (start_btn) begin
        m_state = 1; m_cdt = 0; m_win = 0; m_prst = 1;
        for (int i = 0; i < 2; i++) begin m_lap[i] = 0; m_cp[i] = 0; end
      end
      1: if (tk) begin
        m_cdt++;
        if (m_cdt == COUNT_SEC * TICK_HZ) m_state = 4;
      end
      4: begin
        if (tk) begin
          for (int i = 0; i < 2; i++) begin
            if (in_box(cx[i], cy[i], 280, 320, 100, 140)) m_cp[i] = 1;
            else if (in_box(cx[i], cy[i], 0, 20, 100, 140) && m_cp[i] == 1) begin
              m_lap[i]++;
              m_cp[i] = 0;
            end
          end
          if (m_lap[0] == LAPS || m_lap[1] == LAPS) begin
            m_state = 6;
            m_win = (m_lap[0] == LAPS ? 1 : 0) + (m_lap[1] == LAPS ? 2 : 0);
          end
        end
        if (m_state == 4 && pause_btn) m_state = 5;
      end
      5: if (pause_btn) m_state = 4;
      6: if (start_btn) begin
        m_state = 0; m_win = 0;
        for (int i = 0; i < 2; i++) begin m_lap[i] = 0; m_cp[i] = 0; end
      end
      default: ;
    endcase
    m_n++;
  endtask

  // One clock: edge, model update, compare all outputs on the falling edge
  task automatic step();
    int exp_v, act_v, cd;
    bit tk;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    tk = (m_n % TDIV) == (TDIV - 1);
    cd = (m_state == 1) ? COUNT_SEC - (m_cdt / TICK_HZ) : 0;
    exp_v = (m_state << 14) | (int'(tk) << 13) | (m_prst << 12) | (cd << 10) |
            (m_lap[0] << 6) | (m_lap[1] << 2) | m_win;
    act_v = int'({state, game_tick, phys_rst, countdown, p1_lap, p2_lap, winner});
    check("outputs", act_v, exp_v);
  endtask

  task automatic align();
    while ((m_n % TDIV) != 0) step();
  endtask

  task automatic pulse_start();
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
  endtask

  task automatic wait_state(input int tgt, input int budget, input string nm);
    int k;
    k = 0;
    while (state != 3'(tgt) && k < budget) begin
      step();
      k++;
    end
    check(nm, int'(state), tgt);
  endtask

  task automatic set_pos(input int x1, input int y1, input int x2, input int y2);
    p1_x = 10'(x1); p1_y = 10'(y1); p2_x = 10'(x2); p2_y = 10'(y2);
  endtask

  task automatic rand_pos(output logic [9:0] x, output logic [9:0] y);
    case ($urandom_range(0, 5))
      0: begin x = 10'($urandom_range(0, 20));    y = 10'($urandom_range(100, 140)); end
      1: begin x = 10'($urandom_range(280, 320)); y = 10'($urandom_range(100, 140)); end
      2: begin x = 10'($urandom);                 y = 10'($urandom); end
      3: begin x = 10'd21;                        y = 10'($urandom_range(99, 141)); end
      4: begin x = 10'($urandom_range(279, 321)); y = 10'd141; end
      default: begin x = 10'h3FF;                 y = 10'd120; end
    endcase
  endtask

  task automatic async_reset_check(input string nm);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check(nm, int'({state, game_tick, phys_rst, countdown, p1_lap, p2_lap, winner}), 0);
    @(negedge clk);
    rst = 1'b1;
    m_reset();
  endtask

  initial begin
    int nt, k;

    //              st pa   x1   y1   x2   y2 nt  st l1 l2 w
    tbl[0]  = '{0, 0,   10, 120, 500, 500, 1,  4, 0, 0, 0};
    tbl[1]  = '{0, 0,  279, 120, 500, 500, 1,  4, 0, 0, 0};
    tbl[2]  = '{0, 0,   10, 120, 500, 500, 1,  4, 0, 0, 0};
    tbl[3]  = '{0, 0,  280, 140, 500, 500, 1,  4, 0, 0, 0};
    tbl[4]  = '{0, 0,   21, 120, 500, 500, 1,  4, 0, 0, 0};
    tbl[5]  = '{0, 0,   20, 100, 500, 500, 1,  4, 1, 0, 0};
    tbl[6]  = '{0, 0,   20, 100, 500, 500, 1,  4, 1, 0, 0};
    tbl[7]  = '{0, 1,  300, 120, 500, 500, 2,  5, 1, 0, 0};
    tbl[8]  = '{0, 0,   10, 120, 500, 500, 2,  5, 1, 0, 0};
    tbl[9]  = '{1, 0,   10, 120, 500, 500, 1,  5, 1, 0, 0};
    tbl[10] = '{0, 1,   10, 120, 500, 500, 1,  4, 1, 0, 0};
    tbl[11] = '{1, 0,  320, 100, 500, 500, 1,  4, 1, 0, 0};
    tbl[12] = '{0, 0, 1023, 120, 500, 500, 1,  4, 1, 0, 0};
    tbl[13] = '{0, 0,    0, 140, 500, 500, 1,  4, 2, 0, 0};
    tbl[14] = '{0, 0,  300, 141, 300, 120, 1,  4, 2, 0, 0};
    tbl[15] = '{0, 0,  300, 120,  22, 120, 1,  4, 2, 0, 0};
    tbl[16] = '{0, 0,   15, 130,  10, 120, 1,  6, 3, 1, 1};
    tbl[17] = '{0, 1,  300, 120, 500, 500, 1,  6, 3, 1, 1};
    tbl[18] = '{1, 0,  500, 500, 500, 500, 1,  0, 0, 0, 0};

    // Reset state
    m_reset();
    #12;
    check("reset_outputs", int'({state, game_tick, phys_rst, countdown, p1_lap, p2_lap, winner}), 0);
    @(negedge clk);
    rst = 1'b1;
    m_reset();

    // Idle: free-running tick
    nt = 0;
    for (int i = 0; i < 35; i++) begin
      step();
      if (game_tick) nt++;
    end
    check("idle_tick_count", nt, 3);

    // Start countdown
    pulse_start();
    check("cd_state", int'(state), 1);
    check("cd_phys_rst", int'(phys_rst), 1);
    check("cd_init", int'(countdown), COUNT_SEC);
    nt = int'(game_tick);
    step();
    check("phys_rst_once", int'(phys_rst), 0);
    k = 0;
    while (state != 3'd4 && k < 3000) begin
      if (game_tick) nt++;
      start_btn = (k == 100);
      pause_btn = (k == 300);
      step();
      k++;
    end
    start_btn = 1'b0;
    pause_btn = 1'b0;
    check("cd_reach_race", int'(state), 4);
    check("cd_tick_len", nt, COUNT_SEC * TICK_HZ);

    // Scripted race from the vector table
    for (int i = 0; i < 19; i++) begin
      align();
      set_pos(tbl[i].x1, tbl[i].y1, tbl[i].x2, tbl[i].y2);
      start_btn = tbl[i].st;
      pause_btn = tbl[i].pa;
      step();
      start_btn = 1'b0;
      pause_btn = 1'b0;
      repeat (tbl[i].nt * TDIV - 1) step();
      check($sformatf("vec%0d_state", i), int'(state),  tbl[i].e_state);
      check($sformatf("vec%0d_lap1", i),  int'(p1_lap), tbl[i].e_l1);
      check($sformatf("vec%0d_lap2", i),  int'(p2_lap), tbl[i].e_l2);
      check($sformatf("vec%0d_win", i),   int'(winner), tbl[i].e_win);
    end

    // Tie: both cars finish on the same tick
    pulse_start();
    wait_state(4, 2500, "tie_race");
    for (int lap = 1; lap <= LAPS; lap++) begin
      align();
      set_pos(300, 120, 290, 110);
      repeat (TDIV) step();
      set_pos(10, 120, 5, 135);
      repeat (TDIV) step();
      check($sformatf("tie_lap1_%0d", lap), int'(p1_lap), lap);
      check($sformatf("tie_lap2_%0d", lap), int'(p2_lap), lap);
    end
    check("tie_state", int'(state), 6);
    check("tie_winner", int'(winner), 3);
    set_pos(500, 500, 500, 500);
    pulse_start();
    check("tie_restart", int'({state, p1_lap, p2_lap, winner}), 0);

    // Asynchronous reset during countdown and during a race
    pulse_start();
    repeat (500) step();
    async_reset_check("rst_mid_count");
    repeat (5) step();
    check("idle_after_rst1", int'(state), 0);
    pulse_start();
    wait_state(4, 2500, "rst_race");
    align();
    set_pos(300, 120, 500, 500);
    repeat (2 * TDIV) step();
    set_pos(10, 120, 500, 500);
    repeat (2 * TDIV) step();
    check("pre_rst_lap", int'(p1_lap), 1);
    async_reset_check("rst_mid_race");
    repeat (5) step();
    check("idle_after_rst2", int'(state), 0);

    // Random races against the model
    for (int r = 0; r < 3; r++) begin
      pulse_start();
      wait_state(4, 2500, "rand_race");
      k = 0;
      while (state != 3'd6 && k < 4000) begin
        if ($urandom_range(0, 3) == 0) rand_pos(p1_x, p1_y);
        if ($urandom_range(0, 3) == 0) rand_pos(p2_x, p2_y);
        pause_btn = ($urandom_range(0, 39) == 0);
        start_btn = ($urandom_range(0, 59) == 0);
        step();
        k++;
      end
      start_btn = 1'b0;
      pause_btn = 1'b0;
      check("rand_finish", int'(state), 6);
      step();
      pulse_start();
      check("rand_idle", int'(state), 0);
      repeat (3) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
